// File: rtl/forward_select_unit.sv
// Tracks EX/MEM/WB destination registers, registers the ALU operand-forward selects and raises the load-use stall.
// Optional macro REGFILE_BYPASS_EN: also compare the WB slot and emit select 11 for a hit there.
module forward_select_unit #(
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      hold,
    input  logic                      flush,
    input  logic                      id_valid,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    input  logic                      id_use_rs1,
    input  logic                      id_use_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd,
    input  logic                      id_reg_write,
    input  logic                      id_mem_read,
    output logic [1:0]                fwd_a_sel,
    output logic [1:0]                fwd_b_sel,
    output logic                      stall
);

    localparam int unsigned SEL_W = 2;

    typedef logic [SEL_W-1:0] sel_t;

    localparam sel_t SEL_RF  = SEL_W'(0);
    localparam sel_t SEL_MEM = SEL_W'(1);
    localparam sel_t SEL_WB  = SEL_W'(2);
`ifdef REGFILE_BYPASS_EN
    localparam sel_t SEL_BYP = SEL_W'(3);
`endif

    typedef struct packed {
        logic                      valid;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      is_load;
    } slot_t;

    slot_t ex_q, mem_q, wb_q;
    slot_t ex_d;
    sel_t  fwd_a_d, fwd_b_d;
    logic  load_hit;
    logic  issue;

    // A used, non-zero source that names the register a valid slot will write.
    function automatic logic src_hit(input logic                      use_rs,
                                     input logic [REG_ADDR_WIDTH-1:0] rs,
                                     input slot_t                     s);
        return use_rs && (rs != '0) && s.valid && (rs == s.rd);
    endfunction

    // Nearest producer wins; a load in EX is never forwarded (the stall covers it).
    function automatic sel_t pick_sel(input logic                      use_rs,
                                      input logic [REG_ADDR_WIDTH-1:0] rs,
                                      input slot_t                     ex_s,
                                      input slot_t                     mem_s,
                                      input slot_t                     wb_s);
        sel_t sel;
        sel = SEL_RF;
        if (src_hit(use_rs, rs, ex_s) && !ex_s.is_load) begin
            sel = SEL_MEM;
        end else if (src_hit(use_rs, rs, mem_s)) begin
            sel = SEL_WB;
`ifdef REGFILE_BYPASS_EN
        end else if (src_hit(use_rs, rs, wb_s)) begin
            sel = SEL_BYP;
`endif
        end
`ifndef REGFILE_BYPASS_EN
        if (wb_s.valid && 1'b0) begin
            sel = SEL_RF;
        end
`endif
        return sel;
    endfunction

    // Load-use hazard and the next EX-slot / select values.
    always_comb begin
        load_hit = 1'b0;
        stall    = 1'b0;
        issue    = 1'b0;
        ex_d     = '0;
        fwd_a_d  = SEL_RF;
        fwd_b_d  = SEL_RF;

        load_hit = ex_q.valid && ex_q.is_load &&
                   (src_hit(id_use_rs1, id_rs1, ex_q) || src_hit(id_use_rs2, id_rs2, ex_q));
        stall    = id_valid && !flush && load_hit;
        issue    = id_valid && !flush && !stall;

        if (issue && id_reg_write && (id_rd != '0)) begin
            ex_d.valid   = 1'b1;
            ex_d.rd      = id_rd;
            ex_d.is_load = id_mem_read;
        end

        if (issue) begin
            fwd_a_d = pick_sel(id_use_rs1, id_rs1, ex_q, mem_q, wb_q);
            fwd_b_d = pick_sel(id_use_rs2, id_rs2, ex_q, mem_q, wb_q);
        end
    end

    // Shadow pipeline and registered selects; hold freezes everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            fwd_a_sel <= SEL_RF;
            fwd_b_sel <= SEL_RF;
        end else if (!hold) begin
            wb_q      <= mem_q;
            mem_q     <= ex_q;
            ex_q      <= ex_d;
            fwd_a_sel <= fwd_a_d;
            fwd_b_sel <= fwd_b_d;
        end
    end

    // Load flags of the older slots are carried for visibility only.
    logic unused_slot_bits;
`ifdef REGFILE_BYPASS_EN
    assign unused_slot_bits = ^{mem_q.is_load, wb_q.is_load};
`else
    assign unused_slot_bits = ^{mem_q.is_load, wb_q};
`endif

endmodule

// File: tb/tb_forward_select_unit.sv
// Self-checking bench for forward_select_unit: directed hazard scenarios plus randomized traffic vs an instruction-history model.
module tb_forward_select_unit;

    localparam int AW = 5;
`ifdef REGFILE_BYPASS_EN
    localparam int DEPTH = 3;
`else
    localparam int DEPTH = 2;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          hold, flush, id_valid;
    logic [AW-1:0] id_rs1, id_rs2, id_rd;
    logic          id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
    logic [1:0]    fwd_a_sel, fwd_b_sel;
    logic          stall;

    int checks = 0;
    int errors = 0;

    forward_select_unit #(.REG_ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .hold(hold), .flush(flush), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall)
    );

    always #5 clk = ~clk;

    // Model: hist[d] is the instruction issued d+1 cycles before the one now in ID.
    typedef struct {
        logic          w;
        logic [AW-1:0] rd;
        logic          ld;
    } ent_t;

    ent_t       hist[3];
    logic [1:0] exp_a, exp_b;

    function automatic logic m_match(input logic u, input logic [AW-1:0] rs, input int d);
        return u && (rs != 0) && hist[d].w && (hist[d].rd == rs);
    endfunction

    function automatic logic m_stall();
        return id_valid && !flush && hist[0].w && hist[0].ld &&
               (m_match(id_use_rs1, id_rs1, 0) || m_match(id_use_rs2, id_rs2, 0));
    endfunction

    // Producer distance d (1-based) maps directly to select code d.
    function automatic logic [1:0] m_sel(input logic u, input logic [AW-1:0] rs);
        for (int d = 0; d < DEPTH; d++) begin
            if (m_match(u, rs, d) && !(d == 0 && hist[0].ld)) return 2'(d + 1);
        end
        return 2'd0;
    endfunction

    task automatic m_clear();
        for (int d = 0; d < 3; d++) begin
            hist[d].w = 1'b0; hist[d].rd = '0; hist[d].ld = 1'b0;
        end
        exp_a = 2'd0;
        exp_b = 2'd0;
    endtask

    task automatic m_edge();
        logic issue;
        ent_t ne;
        if (!hold) begin
            issue = id_valid && !flush && !m_stall();
            exp_a = issue ? m_sel(id_use_rs1, id_rs1) : 2'd0;
            exp_b = issue ? m_sel(id_use_rs2, id_rs2) : 2'd0;
            ne.w  = issue && id_reg_write && (id_rd != 0);
            ne.rd = id_rd;
            ne.ld = id_mem_read;
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = ne;
        end
    endtask

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] r1, input logic u1,
                         input logic [AW-1:0] r2, input logic u2, input logic [AW-1:0] rd,
                         input logic wr, input logic ld, input logic fl, input logic hd);
        @(negedge clk);
        id_valid = v; id_rs1 = r1; id_use_rs1 = u1; id_rs2 = r2; id_use_rs2 = u2;
        id_rd = rd; id_reg_write = wr; id_mem_read = ld; flush = fl; hold = hd;
        #1;
    endtask

    // Check stall mid-cycle, advance one edge, check the registered selects.
    task automatic tick();
        check("stall_model", {1'b0, stall}, {1'b0, m_stall()});
        m_edge();
        @(posedge clk);
        #1;
        check("fwd_a_model", fwd_a_sel, exp_a);
        check("fwd_b_model", fwd_b_sel, exp_b);
    endtask

    task automatic nop();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    // Writer of rd, optionally a load, reading nothing.
    task automatic wr_op(input logic [AW-1:0] rd, input logic ld);
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, rd, 1'b1, ld, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        reset = 1'b0;
        m_clear();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_a", fwd_a_sel, 2'd0);
        check("reset_b", fwd_b_sel, 2'd0);
        check("reset_stall", {1'b0, stall}, 2'd0);
        @(negedge clk);
        reset = 1'b1;

        // ALU back-to-back: add x5 ; sub x8, x5, x6
        wr_op(5'd5, 1'b0);
        drive(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check("b2b_a", fwd_a_sel, 2'd1);
        check("b2b_b", fwd_b_sel, 2'd0);
        nop(); nop(); nop();

        // Distance 2: add x7 ; nop ; or rs2=x7
        wr_op(5'd7, 1'b0);
        nop();
        drive(1'b1, 5'd1, 1'b1, 5'd7, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check("dist2_b", fwd_b_sel, 2'd2);
        nop(); nop(); nop();
        wr_op(5'd0, 1'b0);
        nop();
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check("dist2_x0_b", fwd_b_sel, 2'd0);
        nop(); nop(); nop();

        // Load-use: lw x3 ; add rs1=x3 -> one stall, bubble, then select 10
        wr_op(5'd3, 1'b1);
        drive(1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
        check("lu_stall", {1'b0, stall}, 2'd1);
        tick();
        check("lu_bubble_a", fwd_a_sel, 2'd0);
        check("lu_bubble_b", fwd_b_sel, 2'd0);
        drive(1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
        check("lu_release", {1'b0, stall}, 2'd0);
        tick();
        check("lu_fwd_a", fwd_a_sel, 2'd2);
        nop(); nop(); nop();

        // Flush with a load-use match: no stall, flushed add never enters EX
        wr_op(5'd4, 1'b1);
        drive(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0);
        check("flush_stall", {1'b0, stall}, 2'd0);
        tick();
        check("flush_a", fwd_a_sel, 2'd0);
        drive(1'b1, 5'd10, 1'b1, 5'd4, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check("flush_ex_invalid_a", fwd_a_sel, 2'd0);
        check("flush_load_mem_b", fwd_b_sel, 2'd2);
        nop(); nop(); nop();

        // Hold for 3 cycles with a pending load-use
        wr_op(5'd11, 1'b0);
        drive(1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        check("hold_pre_a", fwd_a_sel, 2'd1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b1);
            check("hold_stall", {1'b0, stall}, 2'd1);
            tick();
            check("hold_a", fwd_a_sel, 2'd1);
        end
        drive(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0);
        check("hold_release_stall", {1'b0, stall}, 2'd1);
        tick();
        drive(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check("hold_after_a", fwd_a_sel, 2'd2);
        nop(); nop(); nop();

        // WB-slot distance: add x9 ; nop ; nop ; reader of x9
        wr_op(5'd9, 1'b0);
        nop(); nop();
        drive(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
`ifdef REGFILE_BYPASS_EN
        check("bypass_a", fwd_a_sel, 2'd3);
`else
        check("bypass_a", fwd_a_sel, 2'd0);
`endif
        nop(); nop(); nop();

        // Asynchronous reset mid-stream with slots full
        wr_op(5'd12, 1'b0);
        wr_op(5'd13, 1'b0);
        drive(1'b1, 5'd13, 1'b1, 5'd0, 1'b0, 5'd14, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        check("pre_reset_a", fwd_a_sel, 2'd1);
        drive(1'b1, 5'd14, 1'b1, 5'd13, 1'b1, 5'd15, 1'b1, 1'b0, 1'b0, 1'b0);
        check("pre_reset_stall", {1'b0, stall}, 2'd1);
        #1;
        reset = 1'b0;
        m_clear();
        #1;
        check("async_reset_a", fwd_a_sel, 2'd0);
        check("async_reset_b", fwd_b_sel, 2'd0);
        check("async_reset_stall", {1'b0, stall}, 2'd0);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, 5'd14, 1'b1, 5'd13, 1'b1, 5'd15, 1'b1, 1'b0, 1'b0, 1'b0);
        check("post_reset_stall", {1'b0, stall}, 2'd0);
        tick();
        check("post_reset_a", fwd_a_sel, 2'd0);
        check("post_reset_b", fwd_b_sel, 2'd0);

        // Randomized traffic over a small register set to provoke hazards
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 9) < 8),
                  AW'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  AW'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  AW'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 9) < 3),
                  1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) == 0));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
